// File: rtl/stream_mux_rr_if.sv
// ============================================================================
// stream_mux_rr_if : N-channel input streams, force controls and output stream
// Rev 1.0
// ============================================================================
`default_nettype none

interface stream_mux_rr_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 64,
   parameter int CH_W   = $clog2(NUM_CH)
);
   logic [NUM_CH-1:0]        in_valid;
   logic [NUM_CH*DATA_W-1:0] in_data;
   logic [NUM_CH-1:0]        in_last;
   logic [NUM_CH-1:0]        in_ready;
   logic                     force_en;
   logic [CH_W-1:0]          force_ch;
   logic                     out_valid;
   logic [DATA_W-1:0]        out_data;
   logic                     out_last;
   logic [CH_W-1:0]          out_ch;
   logic                     out_ready;

   // master: the environment around the mux (sources, sink, select control)
   modport master (
      output in_valid, in_data, in_last, force_en, force_ch, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_ch
   );

   // slave: the multiplexer itself
   modport slave (
      input  in_valid, in_data, in_last, force_en, force_ch, out_ready,
      output in_ready, out_valid, out_data, out_last, out_ch
   );
endinterface

`default_nettype wire

// File: rtl/stream_mux_rr.sv
// ============================================================================
// stream_mux_rr : registered round-robin / forced-select N-channel stream mux
// Rev 1.0
// ============================================================================
`default_nettype none

module stream_mux_rr #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 64,
   parameter int CH_W   = $clog2(NUM_CH)
) (
   input  logic           clk,
   input  logic           rst_n,
   stream_mux_rr_if.slave bus
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t              state;
   logic [CH_W-1:0]     ptr;
   logic [CH_W-1:0]     lock_ch;

   logic [NUM_CH-1:0]   grant;
   logic [CH_W-1:0]     gnt_ch;
   logic [CH_W-1:0]     next_ptr;
   logic [CH_W-1:0]     rr_idx;
   logic                rr_found;
   logic [DATA_W-1:0]   sel_data;
   logic                sel_last;
   logic                can_load;
   logic                xfer;

   // Grant selection: locked channel, forced channel, or first valid from ptr
   always_comb begin
      grant    = '0;
      gnt_ch   = '0;
      rr_idx   = '0;
      rr_found = 1'b0;
      if (state == ST_LOCKED) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (lock_ch == CH_W'(i)) begin
               grant[i] = bus.in_valid[i];
               gnt_ch   = CH_W'(i);
            end
         end
      end else if (bus.force_en) begin
         // out-of-range force_ch matches no channel, so nothing is granted
         for (int i = 0; i < NUM_CH; i++) begin
            if (bus.force_ch == CH_W'(i)) begin
               grant[i] = bus.in_valid[i];
               gnt_ch   = CH_W'(i);
            end
         end
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            rr_idx = CH_W'((int'(ptr) + k) % NUM_CH);
            if (!rr_found && bus.in_valid[rr_idx]) begin
               rr_found       = 1'b1;
               grant[rr_idx]  = 1'b1;
               gnt_ch         = rr_idx;
            end
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant[i]) begin
            sel_data = bus.in_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign sel_last     = |(grant & bus.in_last);
   assign can_load     = ~bus.out_valid | bus.out_ready;
   assign bus.in_ready = (rst_n && can_load) ? grant : '0;
   assign xfer         = |(bus.in_ready & bus.in_valid);
   assign next_ptr     = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         ptr           <= '0;
         lock_ch       <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_last  <= 1'b0;
         bus.out_ch    <= '0;
      end else begin
         if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= sel_data;
            bus.out_last  <= sel_last;
            bus.out_ch    <= gnt_ch;
         end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (xfer) begin
                  if (sel_last) begin
                     ptr <= next_ptr;
                  end else begin
                     state   <= ST_LOCKED;
                     lock_ch <= gnt_ch;
                  end
               end
            end
            ST_LOCKED: begin
               if (xfer && sel_last) begin
                  state <= ST_IDLE;
                  ptr   <= next_ptr;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
